// File: rtl/myproject_dense_acc_25s_16s.sv
// Dense-layer accumulator: sums N_IN signed products onto a bias, then rounds and saturates
// the total into the 16-bit activation format, with valid/ready on both stream sides.
module myproject_dense_acc_25s_16s #(
   parameter int unsigned N_IN   = 16,
   parameter int unsigned PROD_W = 25,
   parameter int unsigned ACC_W  = 31,
   parameter int unsigned BIAS_W = 16,
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned SHIFT  = 7
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic signed [PROD_W-1:0] prod_data,
   input  logic                     prod_valid,
   output logic                     prod_ready,
   input  logic signed [BIAS_W-1:0] bias,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_sat,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int unsigned CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (SHIFT - 1);
   localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [0:0] {S_ACC, S_OUT} state_t;

   state_t                   r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [OUT_W-1:0]  r_out_data;
   logic                     r_out_sat;

   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_bias_ext;
   logic signed [ACC_W-1:0]  w_bias_acc;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  w_rnd_pre;
   logic signed [ACC_W-1:0]  w_rnd;
   logic signed [OUT_W-1:0]  w_sat_data;
   logic                     w_sat_flag;

   assign w_prod_ext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
   assign w_bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
   // Bias is aligned to the product's fractional point before seeding the accumulator.
   assign w_bias_acc = w_bias_ext <<< SHIFT;
   assign w_sum      = r_acc + w_prod_ext;
   assign w_rnd_pre  = w_sum + RND_HALF;
   assign w_rnd      = w_rnd_pre >>> SHIFT;

   always_comb begin
      w_sat_data = w_rnd[OUT_W-1:0];
      w_sat_flag = 1'b0;
      if (w_rnd > OUT_MAX) begin
         w_sat_data = {1'b0, {(OUT_W-1){1'b1}}};
         w_sat_flag = 1'b1;
      end else if (w_rnd < OUT_MIN) begin
         w_sat_data = {1'b1, {(OUT_W-1){1'b0}}};
         w_sat_flag = 1'b1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state    <= S_ACC;
         r_cnt      <= '0;
         r_acc      <= w_bias_acc;
         r_out_data <= '0;
         r_out_sat  <= 1'b0;
      end else begin
         unique case (r_state)
            S_ACC: begin
               if (prod_valid) begin
                  if (r_cnt == CNT_LAST) begin
                     r_out_data <= w_sat_data;
                     r_out_sat  <= w_sat_flag;
                     r_state    <= S_OUT;
                  end else begin
                     r_acc <= w_sum;
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            S_OUT: begin
               // Output pop reloads the bias; no product is taken on this edge.
               if (out_ready) begin
                  r_state <= S_ACC;
                  r_cnt   <= '0;
                  r_acc   <= w_bias_acc;
               end
            end
            default: r_state <= S_ACC;
         endcase
      end
   end

   assign prod_ready = (r_state == S_ACC);
   assign out_valid  = (r_state == S_OUT);
   assign out_data   = r_out_data;
   assign out_sat    = r_out_sat;

endmodule

// File: tb/tb_myproject_dense_acc_25s_16s.sv
// Randomised and directed bench for the dense accumulator, checked every cycle against a
// longint model of the neuron sum, rounding and saturation rules.
module tb_myproject_dense_acc_25s_16s;

   localparam int N_IN = 16;

   logic               ap_clk = 1'b0;
   logic               ap_rst;
   logic signed [24:0] prod_data;
   logic               prod_valid;
   logic               prod_ready;
   logic signed [15:0] bias;
   logic signed [15:0] out_data;
   logic               out_sat;
   logic               out_valid;
   logic               out_ready;

   myproject_dense_acc_25s_16s dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .prod_data  (prod_data),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .bias       (bias),
      .out_data   (out_data),
      .out_sat    (out_sat),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 ap_clk = ~ap_clk;

   int d_checks = 0, d_pass = 0;
   int a_checks = 0, a_pass = 0;

   // Behavioural model: real-valued neuron sum in units of 2^-17, rounded half up.
   bit     m_live = 1'b0;
   bit     m_out  = 1'b0;
   int     m_cnt  = 0;
   int     m_nout = 0;
   longint m_sum  = 0;
   longint m_exp_data = 0;
   bit     m_exp_sat  = 1'b0;

   function automatic longint rnd(input longint s);
      longint t = s + 64;
      longint q = t / 128;
      if ((t % 128 != 0) && (t < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint sat_val(input longint s);
      longint q = rnd(s);
      if (q > 32767) return 32767;
      if (q < -32768) return -32768;
      return q;
   endfunction

   function automatic bit sat_flag(input longint s);
      longint q = rnd(s);
      return (q > 32767) || (q < -32768);
   endfunction

   always @(posedge ap_clk) begin
      if (ap_rst) begin
         m_live <= 1'b1;
         m_out  <= 1'b0;
         m_cnt  <= 0;
         m_sum  <= longint'(bias) * 128;
      end else if (!m_out) begin
         if (prod_valid) begin
            if (m_cnt == N_IN - 1) begin
               m_exp_data <= sat_val(m_sum + longint'(prod_data));
               m_exp_sat  <= sat_flag(m_sum + longint'(prod_data));
               m_out      <= 1'b1;
               m_nout     <= m_nout + 1;
            end else begin
               m_sum <= m_sum + longint'(prod_data);
               m_cnt <= m_cnt + 1;
            end
         end
      end else if (out_ready) begin
         m_out <= 1'b0;
         m_cnt <= 0;
         m_sum <= longint'(bias) * 128;
      end
   end

   task automatic cmp(input string name, input longint act, input longint exp);
      a_checks++;
      if (act == exp) a_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   always @(negedge ap_clk) begin
      if (m_live) begin
         cmp("prod_ready", longint'(prod_ready), longint'(!m_out));
         cmp("out_valid", longint'(out_valid), longint'(m_out));
         if (m_out && out_valid) begin
            cmp("out_data", longint'(out_data), m_exp_data);
            cmp("out_sat", longint'(out_sat), longint'(m_exp_sat));
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      d_checks++;
      if (act == exp) d_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // All driver tasks start and end at posedge+1.
   task automatic push(input longint p);
      bit hs = 1'b0;
      int n = 0;
      prod_data  = 25'(p);
      prod_valid = 1'b1;
      while (!hs && n < 200) begin
         @(negedge ap_clk);
         hs = prod_ready;
         @(posedge ap_clk);
         #1;
         n++;
      end
      if (!hs) chk("push_timeout", 0, 1);
      prod_valid = 1'b0;
   endtask

   task automatic group(input longint p_last, input longint p_rest);
      for (int i = 0; i < N_IN - 1; i++) push(p_rest);
      push(p_last);
   endtask

   task automatic get_out(input string name, input longint exp_d, input longint exp_s,
                          input logic signed [15:0] next_bias);
      int n = 0;
      while (!out_valid && n < 50) begin
         @(posedge ap_clk);
         #1;
         n++;
      end
      chk({name, "_valid"}, longint'(out_valid), 1);
      chk({name, "_data"}, longint'(out_data), exp_d);
      chk({name, "_sat"}, longint'(out_sat), exp_s);
      chk({name, "_model"}, m_exp_data, exp_d);
      bias      = next_bias;
      out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
   endtask

   initial begin
      logic [31:0] rv;
      ap_rst = 1'b1; prod_data = '0; prod_valid = 1'b0; bias = '0; out_ready = 1'b1;
      repeat (2) @(posedge ap_clk);
      #1 ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("rst_prod_ready", longint'(prod_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      @(posedge ap_clk);
      #1;

      for (int i = 0; i < N_IN - 1; i++) push(128);
      chk("lat_pre", longint'(out_valid), 0);
      push(128);
      chk("lat_post", longint'(out_valid), 1);
      get_out("b2b128", 16, 0, 0);

      group(64, 0);  get_out("rnd_p64", 1, 0, 0);
      group(63, 0);  get_out("rnd_p63", 0, 0, 0);
      group(-64, 0); get_out("rnd_m64", 0, 0, 0);
      group(-65, 0); get_out("rnd_m65", -1, 0, 0);

      group(16777215, 16777215);   get_out("sat_pos", 32767, 1, 0);
      group(-16777216, -16777216); get_out("sat_neg", -32768, 1, 32767);
      group(0, 0);                 get_out("bias_max", 32767, 0, 0);

      out_ready = 1'b0;
      group(128, 128);
      for (int i = 0; i < 5; i++) begin
         prod_valid = 1'b1;
         prod_data  = 25'sd5;
         @(negedge ap_clk);
         chk("bp_valid", longint'(out_valid), 1);
         chk("bp_prod_ready", longint'(prod_ready), 0);
         chk("bp_data", longint'(out_data), 16);
         @(posedge ap_clk);
         #1;
      end
      prod_valid = 1'b0;
      get_out("bp_pop", 16, 0, 100);
      bias = 0;
      group(0, 0); get_out("bias100", 100, 0, 0);

      for (int i = 0; i < 7; i++) push(1000);
      ap_rst = 1'b1;
      @(posedge ap_clk);
      #1 ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("midrst_valid", longint'(out_valid), 0);
      @(posedge ap_clk);
      #1;
      group(128, 128); get_out("after_rst", 16, 0, 0);

      // Random gaps, backpressure, bias and product magnitudes; the compare process checks.
      for (int c = 0; c < 4000; c++) begin
         rv = $urandom;
         prod_valid = ($urandom_range(0, 3) != 0);
         if (rv[31:30] == 2'b00) prod_data = rv[24:0];
         else prod_data = 25'($signed($urandom_range(0, 2047)) - 1024);
         rv = $urandom;
         if (rv[3:0] == 4'd0) bias = rv[31:16];
         else bias = 16'($signed($urandom_range(0, 255)) - 128);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge ap_clk);
         #1;
      end
      prod_valid = 1'b0;
      out_ready  = 1'b1;
      repeat (3) @(posedge ap_clk);
      chk("rand_outputs", longint'(m_nout >= 150), 1);
      @(negedge ap_clk);

      $display("%0d/%0d checks passed", d_pass + a_pass, d_checks + a_checks);
      $finish;
   end

endmodule
